// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounced button bank.
// Build option: DEBOUNCE_RAW_COUNT_EN adds raw (pre-debounce) edge counters.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_HIGH,
        S_HIGH,
        S_WAIT_LOW
    } deb_state_t;

    // The timer counts 0..cycles-1, so it needs clog2(cycles) bits and at least one.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchronizer, debounce FSM, press one-shot and press counter.
// Build option: DEBOUNCE_RAW_COUNT_EN adds raw_count, which counts synchronized rising edges.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int CNT_W           = 8,
    parameter int CNT_SAT         = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             noisy,
    input  logic             clear,
    output logic             debounced,
    output logic             press_pulse,
    output logic [CNT_W-1:0] count
`ifdef DEBOUNCE_RAW_COUNT_EN
    ,
    output logic [CNT_W-1:0] raw_count
`endif
);

    localparam int                 TIMER_W    = timer_width(DEBOUNCE_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    deb_state_t             state_q;
    logic [TIMER_W-1:0]     timer_q;
    logic                   debounced_q;
    logic                   press_pulse_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] value);
        if ((CNT_SAT != 0) && (value == '1)) return value;
        return value + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], noisy};
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // debounced and press_pulse are set on the same edge as the state change they reflect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_LOW;
            timer_q       <= '0;
            debounced_q   <= 1'b0;
            press_pulse_q <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every decision below sees pre-edge values.
            press_pulse_q <= 1'b0;
            case (state_q)
                S_LOW: begin
                    if (sync) begin
                        state_q <= S_WAIT_HIGH;
                        timer_q <= '0;
                    end
                end
                S_WAIT_HIGH: begin
                    if (!sync) begin
                        state_q <= S_LOW;
                    end else if (timer_q == TIMER_LAST) begin
                        state_q       <= S_HIGH;
                        debounced_q   <= 1'b1;
                        press_pulse_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!sync) begin
                        state_q <= S_WAIT_LOW;
                        timer_q <= '0;
                    end
                end
                S_WAIT_LOW: begin
                    if (sync) begin
                        state_q <= S_HIGH;
                    end else if (timer_q == TIMER_LAST) begin
                        state_q     <= S_LOW;
                        debounced_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= S_LOW;
            endcase
        end
    end

    // Clear beats a coincident press; that press is dropped.
    always_comb begin
        // NOTE: default first so no branch can leave count_d unassigned and infer a latch.
        count_d = count_q;
        if (clear)              count_d = '0;
        else if (press_pulse_q) count_d = bump(count_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign debounced   = debounced_q;
    assign press_pulse = press_pulse_q;
    assign count       = count_q;

`ifdef DEBOUNCE_RAW_COUNT_EN
    logic             sync_prev_q;
    logic             raw_rise_q;
    logic [CNT_W-1:0] raw_count_q;
    logic [CNT_W-1:0] raw_count_d;

    always_comb begin
        raw_count_d = raw_count_q;
        if (clear)           raw_count_d = '0;
        else if (raw_rise_q) raw_count_d = bump(raw_count_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_prev_q <= 1'b0;
            raw_rise_q  <= 1'b0;
            raw_count_q <= '0;
        end else begin
            sync_prev_q <= sync;
            raw_rise_q  <= sync & ~sync_prev_q;
            raw_count_q <= raw_count_d;
        end
    end

    assign raw_count = raw_count_q;
`endif

endmodule

// File: rtl/debounce_counter_bank.sv
// N-channel debounced button front end with packed press counters for a display.
// Build option: DEBOUNCE_RAW_COUNT_EN adds the raw_count bus (bounce visibility).
module debounce_counter_bank
    import debounce_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int CNT_W           = 8,
    parameter int CNT_SAT         = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       noisy,
    input  logic                    clear,
    output logic [NUM_CH-1:0]       debounced,
    output logic [NUM_CH-1:0]       press_pulse,
    output logic [NUM_CH*CNT_W-1:0] count
`ifdef DEBOUNCE_RAW_COUNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] raw_count
`endif
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .CNT_SAT        (CNT_SAT)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .noisy      (noisy[i]),
            .clear      (clear),
            .debounced  (debounced[i]),
            .press_pulse(press_pulse[i]),
            .count      (count[i*CNT_W +: CNT_W])
`ifdef DEBOUNCE_RAW_COUNT_EN
            ,
            .raw_count  (raw_count[i*CNT_W +: CNT_W])
`endif
        );
    end

endmodule
